cam_mode_sequencer: RTL and testbench
=====================================

CAM_MODE_SEQUENCER -- requirements
Module: cam_mode_sequencer

Interface
REQ-001 SHALL have parameter NUM_CLAUSES, default 256: number of CAM clauses.
REQ-002 SHALL have parameter NUM_VARS, default 32: number of CAM variables.
REQ-003 SHALL have parameter MAX_INFLIGHT, default 4: maximum inference queries issued but not yet retired.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have ports cfg_valid (input, 1) and cfg_ready (output, 1): configuration-command handshake.
REQ-007 SHALL have port cfg_kind, input, 2: command kind; 0 = low threshold, 1 = high threshold, 2 = variable don't-care, 3 = reserved.
REQ-008 SHALL have ports cfg_clause (input, $clog2(NUM_CLAUSES)) and cfg_variable (input, $clog2(NUM_VARS)): command target.
REQ-009 SHALL have ports q_valid (input, 1) and q_ready (output, 1): inference-query handshake.
REQ-010 SHALL have ports mode (output, 3), clause (output, $clog2(NUM_CLAUSES)), variable (output, $clog2(NUM_VARS)) and threshold_kind (output, 1): drive to the CAM core.
REQ-011 SHALL have port core_s_axis_ready, input, 1: CAM core can accept a command this cycle.
REQ-012 SHALL have ports ml_valid (input, 1) and ml_ready (input, 1): observed match-output handshake; a beat retires one query.
REQ-013 SHALL have ports order_err (output, 1) and inflight (output, $clog2(MAX_INFLIGHT+1)): sticky ordering error and outstanding-query count.

Function
REQ-014 SHALL encode mode as 0 = IDLE, 1 = INFER, 2 = WRITE_THRESH, 3 = SET_DONTCARE; all other codes are unused.
REQ-015 SHALL implement states S_IDLE, S_CFG, S_INFER and S_DRAIN.
REQ-016 SHALL assert cfg_ready only when state is S_IDLE or S_CFG, inflight == 0 and core_s_axis_ready == 1.
REQ-017 SHALL assert q_ready only when state is S_IDLE or S_INFER, cfg_valid == 0, inflight < MAX_INFLIGHT and core_s_axis_ready == 1; configuration has strict priority.
REQ-018 SHALL register the command outputs on an accepted beat, one-cycle pulse:
- mode, clause, variable and threshold_kind appear the cycle after acceptance.
- mode returns to 0 on the following cycle unless another beat is accepted.
REQ-019 SHALL drive a threshold command (kind 0/1) as mode = 2, threshold_kind = cfg_kind[0] and clause = cfg_clause.
REQ-020 SHALL drive a don't-care command (kind 2) as mode = 3 with both clause and variable driven.
REQ-021 SHALL drive a query as mode = 1 and SHALL increment inflight.
REQ-022 SHALL decrement inflight on every cycle with ml_valid && ml_ready.
REQ-023 SHALL leave inflight unchanged when an increment and a decrement occur in the same cycle.
REQ-024 SHALL handle ordering:
- Set a dontcare_seen flag when a kind-2 command is accepted.
- A later kind-0/1 command is still consumed, but produces no core pulse and sets order_err.
- Kind 3 is consumed, produces no core pulse and sets order_err.
REQ-025 SHALL make these state transitions:
- S_IDLE goes to S_CFG on cfg accept and to S_INFER on query accept.
- S_CFG goes to S_IDLE when no cfg beat is accepted in a cycle.
- S_INFER goes to S_DRAIN when cfg_valid is seen.
- S_INFER goes to S_IDLE when inflight reaches 0 and q_valid == 0.
- S_DRAIN goes to S_IDLE when inflight == 0.
REQ-026 SHALL accept nothing in S_DRAIN.
REQ-027 SHALL never let inflight exceed MAX_INFLIGHT or go below 0; a retire with inflight == 0 is ignored and sets order_err.
REQ-028 SHALL clear dontcare_seen on a cfg beat that arrives after an inference has occurred, so a new programming epoch starts.

Reset
REQ-029 SHALL, on rst, set state = S_IDLE, mode = 0, clause = 0, variable = 0, threshold_kind = 0, inflight = 0, order_err = 0, dontcare_seen = 0, cfg_ready = 0 and q_ready = 0 in the following cycle.
REQ-030 SHALL, on rst asserted mid-operation, discard outstanding query accounting; no pulse is emitted during the reset cycle.

Verification
REQ-031 SHALL test threshold writes: cfg kinds 0 then 1 to clause 5, core ready -> mode = 2 pulses on consecutive cycles with threshold_kind 0 then 1 and clause = 5.
REQ-032 SHALL test don't-care ordering: don't-care on clause 3, variable 7, then low-threshold write -> one mode = 3 pulse, no mode = 2 pulse, order_err = 1.
REQ-033 SHALL test inflight saturation: 6 back-to-back queries with no ml beats and MAX_INFLIGHT = 4 -> exactly 4 mode = 1 pulses, inflight = 4, q_ready = 0.
REQ-034 SHALL test drain before configuration: 2 queries in flight, then cfg_valid -> S_DRAIN, cfg_ready = 0 until 2 ml beats retire, then the cfg pulse is issued.
REQ-035 SHALL test priority: cfg_valid and q_valid together in S_IDLE -> cfg accepted, q_ready = 0.
REQ-036 SHALL test mid-operation reset: rst with inflight = 3 -> next cycle inflight = 0, mode = 0, state S_IDLE.

Source files
------------

// File: rtl/cam_mode_sequencer.sv
// Sequences configuration writes and inference queries onto the CAM core command port,
// tracking outstanding queries and flagging out-of-order programming.
module cam_mode_sequencer #(
   parameter int unsigned NUM_CLAUSES  = 256,
   parameter int unsigned NUM_VARS     = 32,
   parameter int unsigned MAX_INFLIGHT = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              cfg_valid,
   output logic                              cfg_ready,
   input  logic [1:0]                        cfg_kind,
   input  logic [$clog2(NUM_CLAUSES)-1:0]    cfg_clause,
   input  logic [$clog2(NUM_VARS)-1:0]       cfg_variable,
   input  logic                              q_valid,
   output logic                              q_ready,
   output logic [2:0]                        mode,
   output logic [$clog2(NUM_CLAUSES)-1:0]    clause,
   output logic [$clog2(NUM_VARS)-1:0]       variable,
   output logic                              threshold_kind,
   input  logic                              core_s_axis_ready,
   input  logic                              ml_valid,
   input  logic                              ml_ready,
   output logic                              order_err,
   output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight
);

   localparam int unsigned CW = $clog2(NUM_CLAUSES);
   localparam int unsigned VW = $clog2(NUM_VARS);
   localparam int unsigned IW = $clog2(MAX_INFLIGHT + 1);
   localparam logic [IW-1:0] MAX_CNT = IW'(MAX_INFLIGHT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CFG,
      S_INFER,
      S_DRAIN
   } state_t;

   typedef enum logic [2:0] {
      M_IDLE         = 3'd0,
      M_INFER        = 3'd1,
      M_WRITE_THRESH = 3'd2,
      M_SET_DONTCARE = 3'd3
   } mode_t;

   state_t          state_q, state_d;
   mode_t           mode_q, mode_d;
   logic [CW-1:0]   clause_q, clause_d;
   logic [VW-1:0]   variable_q, variable_d;
   logic            tk_q, tk_d;
   logic [IW-1:0]   inflight_q, inflight_d;
   logic            err_q, err_d;
   logic            dc_seen_q, dc_seen_d;
   logic            infer_seen_q, infer_seen_d;

   logic            cfg_acc, q_acc, retire, dc_eff;

   always_comb begin
      state_d      = state_q;
      mode_d       = M_IDLE;
      clause_d     = clause_q;
      variable_d   = variable_q;
      tk_d         = tk_q;
      inflight_d   = inflight_q;
      err_d        = err_q;
      dc_seen_d    = dc_seen_q;
      infer_seen_d = infer_seen_q;

      cfg_ready = !rst && (state_q == S_IDLE || state_q == S_CFG) &&
                  (inflight_q == '0) && core_s_axis_ready;
      q_ready   = !rst && (state_q == S_IDLE || state_q == S_INFER) && !cfg_valid &&
                  (inflight_q < MAX_CNT) && core_s_axis_ready;

      cfg_acc = cfg_valid && cfg_ready;
      q_acc   = q_valid && q_ready;
      retire  = ml_valid && ml_ready;
      // A cfg beat after any inference opens a new epoch, forgetting earlier don't-cares
      dc_eff  = dc_seen_q && !infer_seen_q;

      if (cfg_acc) begin
         infer_seen_d = 1'b0;
         dc_seen_d    = dc_eff;
         case (cfg_kind)
            2'd0, 2'd1: begin
               if (dc_eff) begin
                  err_d = 1'b1;
               end else begin
                  mode_d   = M_WRITE_THRESH;
                  tk_d     = cfg_kind[0];
                  clause_d = cfg_clause;
               end
            end
            2'd2: begin
               mode_d     = M_SET_DONTCARE;
               clause_d   = cfg_clause;
               variable_d = cfg_variable;
               dc_seen_d  = 1'b1;
            end
            default: err_d = 1'b1;
         endcase
      end else if (q_acc) begin
         mode_d       = M_INFER;
         infer_seen_d = 1'b1;
      end

      if (q_acc && !retire) begin
         inflight_d = inflight_q + IW'(1);
      end else if (retire && !q_acc) begin
         if (inflight_q == '0) begin
            err_d = 1'b1;
         end else begin
            inflight_d = inflight_q - IW'(1);
         end
      end

      case (state_q)
         S_IDLE: begin
            if (cfg_acc) begin
               state_d = S_CFG;
            end else if (q_acc) begin
               state_d = S_INFER;
            end
         end
         S_CFG: begin
            if (!cfg_acc) begin
               state_d = S_IDLE;
            end
         end
         S_INFER: begin
            if (cfg_valid) begin
               state_d = S_DRAIN;
            end else if (inflight_d == '0 && !q_valid) begin
               state_d = S_IDLE;
            end
         end
         S_DRAIN: begin
            if (inflight_q == '0) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         mode_q       <= M_IDLE;
         clause_q     <= '0;
         variable_q   <= '0;
         tk_q         <= 1'b0;
         inflight_q   <= '0;
         err_q        <= 1'b0;
         dc_seen_q    <= 1'b0;
         infer_seen_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         clause_q     <= clause_d;
         variable_q   <= variable_d;
         tk_q         <= tk_d;
         inflight_q   <= inflight_d;
         err_q        <= err_d;
         dc_seen_q    <= dc_seen_d;
         infer_seen_q <= infer_seen_d;
      end
   end

   assign mode           = mode_q;
   assign clause         = clause_q;
   assign variable       = variable_q;
   assign threshold_kind = tk_q;
   assign order_err      = err_q;
   assign inflight       = inflight_q;

endmodule

// File: tb/tb_cam_mode_sequencer.sv
// Scoreboard bench for cam_mode_sequencer: directed scenarios then randomized traffic
// against a transaction-level reference model.
module tb_cam_mode_sequencer;

   localparam int NC   = 256;
   localparam int NV   = 32;
   localparam int MAXI = 4;

   logic       clk = 1'b0;
   logic       rst, cfg_valid, cfg_ready, q_valid, q_ready;
   logic [1:0] cfg_kind;
   logic [7:0] cfg_clause, clause;
   logic [4:0] cfg_variable, variable;
   logic [2:0] mode, inflight;
   logic       threshold_kind, core_s_axis_ready, ml_valid, ml_ready, order_err;

   always #5 clk = ~clk;

   cam_mode_sequencer #(
      .NUM_CLAUSES (NC),
      .NUM_VARS    (NV),
      .MAX_INFLIGHT(MAXI)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .cfg_valid        (cfg_valid),
      .cfg_ready        (cfg_ready),
      .cfg_kind         (cfg_kind),
      .cfg_clause       (cfg_clause),
      .cfg_variable     (cfg_variable),
      .q_valid          (q_valid),
      .q_ready          (q_ready),
      .mode             (mode),
      .clause           (clause),
      .variable         (variable),
      .threshold_kind   (threshold_kind),
      .core_s_axis_ready(core_s_axis_ready),
      .ml_valid         (ml_valid),
      .ml_ready         (ml_ready),
      .order_err        (order_err),
      .inflight         (inflight)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      int cyc;
      int md;
      int cl;
      int vr;
      int tk;
      bit ccl;
      bit cvr;
      bit ctk;
   } pulse_t;

   pulse_t exp_q[$];
   int     edge_n = 0;
   int     seen[4] = '{0, 0, 0, 0};

   // Monitor: every non-idle mode must match the oldest expected pulse, on the expected cycle
   initial begin
      pulse_t p;
      forever begin
         @(posedge clk);
         edge_n++;
         #1;
         if (mode != 3'd0) begin
            if (mode < 3'd4) seen[mode]++;
            if (exp_q.size() == 0) begin
               chk("unexpected_pulse_mode", int'(mode), 0);
            end else begin
               p = exp_q.pop_front();
               chk("pulse_cycle", edge_n, p.cyc);
               chk("pulse_mode", int'(mode), p.md);
               if (p.ccl) chk("pulse_clause", int'(clause), p.cl);
               if (p.cvr) chk("pulse_variable", int'(variable), p.vr);
               if (p.ctk) chk("pulse_threshold_kind", int'(threshold_kind), p.tk);
            end
         end else if (exp_q.size() > 0 && exp_q[0].cyc <= edge_n) begin
            p = exp_q.pop_front();
            chk("missing_pulse_mode", int'(mode), p.md);
         end
      end
   end

   typedef enum {P_IDLE, P_CFG, P_INFER, P_DRAIN} ph_t;
   ph_t m_ph  = P_IDLE;
   int  m_cnt = 0;
   bit  m_err = 1'b0;
   bit  m_dc  = 1'b0;
   bit  m_inf = 1'b0;

   function automatic void push(input int md, input int cl, input int vr, input int tk,
                                input bit ccl, input bit cvr, input bit ctk);
      pulse_t p;
      p.cyc = edge_n + 1;
      p.md  = md;
      p.cl  = cl;
      p.vr  = vr;
      p.tk  = tk;
      p.ccl = ccl;
      p.cvr = cvr;
      p.ctk = ctk;
      exp_q.push_back(p);
   endfunction

   // One clock cycle: drive at the falling edge, check handshakes, advance the model
   task automatic step(input bit r, input bit cv, input int kind, input int cl, input int vr,
                       input bit qv, input bit core, input bit mlv, input bit mlr);
      bit er, eq, ca, qa, ret;
      int old_cnt;
      rst               = r;
      cfg_valid         = cv;
      cfg_kind          = 2'(kind);
      cfg_clause        = 8'(cl);
      cfg_variable      = 5'(vr);
      q_valid           = qv;
      core_s_axis_ready = core;
      ml_valid          = mlv;
      ml_ready          = mlr;
      #1;
      er = !r && (m_ph == P_IDLE || m_ph == P_CFG) && m_cnt == 0 && core;
      eq = !r && (m_ph == P_IDLE || m_ph == P_INFER) && !cv && m_cnt < MAXI && core;
      chk("cfg_ready", int'(cfg_ready), int'(er));
      chk("q_ready", int'(q_ready), int'(eq));
      chk("inflight", int'(inflight), m_cnt);
      chk("order_err", int'(order_err), int'(m_err));
      if (r) begin
         m_ph  = P_IDLE;
         m_cnt = 0;
         m_err = 1'b0;
         m_dc  = 1'b0;
         m_inf = 1'b0;
      end else begin
         ca      = cv && er;
         qa      = qv && eq;
         ret     = mlv && mlr;
         old_cnt = m_cnt;
         if (ca) begin
            if (m_inf) begin
               m_dc  = 1'b0;
               m_inf = 1'b0;
            end
            if (kind == 2) begin
               push(3, cl, vr, 0, 1'b1, 1'b1, 1'b0);
               m_dc = 1'b1;
            end else if (kind == 3 || m_dc) begin
               m_err = 1'b1;
            end else begin
               push(2, cl, 0, kind, 1'b1, 1'b0, 1'b1);
            end
         end else if (qa) begin
            push(1, 0, 0, 0, 1'b0, 1'b0, 1'b0);
            m_inf = 1'b1;
         end
         if (qa && !ret) begin
            m_cnt++;
         end else if (ret && !qa) begin
            if (m_cnt == 0) m_err = 1'b1;
            else m_cnt--;
         end
         case (m_ph)
            P_IDLE:  if (ca) m_ph = P_CFG; else if (qa) m_ph = P_INFER;
            P_CFG:   if (!ca) m_ph = P_IDLE;
            P_INFER: if (cv) m_ph = P_DRAIN; else if (m_cnt == 0 && !qv) m_ph = P_IDLE;
            P_DRAIN: if (old_cnt == 0) m_ph = P_IDLE;
            default: m_ph = P_IDLE;
         endcase
      end
      @(negedge clk);
   endtask

   task automatic idle(input bit r);
      step(r, 1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      int s1, s2, s3;
      rst = 1'b1;
      cfg_valid = 1'b0;
      cfg_kind = '0;
      cfg_clause = '0;
      cfg_variable = '0;
      q_valid = 1'b0;
      core_s_axis_ready = 1'b0;
      ml_valid = 1'b0;
      ml_ready = 1'b0;
      @(negedge clk);
      idle(1'b1);
      chk("reset_mode", int'(mode), 0);
      chk("reset_clause", int'(clause), 0);
      chk("reset_variable", int'(variable), 0);
      chk("reset_threshold_kind", int'(threshold_kind), 0);

      // threshold writes low then high to clause 5
      s2 = seen[2];
      step(1'b0, 1'b1, 0, 5, 0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1, 5, 0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(1'b0);
      chk("thresh_pulse_count", seen[2] - s2, 2);

      // don't-care followed by a threshold write
      s2 = seen[2];
      s3 = seen[3];
      step(1'b0, 1'b1, 2, 3, 7, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 0, 4, 0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(1'b0);
      chk("order_dc_pulses", seen[3] - s3, 1);
      chk("order_thresh_pulses", seen[2] - s2, 0);
      chk("order_err_set", int'(order_err), 1);
      idle(1'b1);

      // saturation: six back-to-back queries, no retires
      idle(1'b0);
      s1 = seen[1];
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(1'b0);
      chk("sat_query_pulses", seen[1] - s1, 4);
      chk("sat_inflight", int'(inflight), 4);
      chk("sat_q_ready", int'(q_ready), 0);

      // retire one, then reset with three outstanding
      step(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("pre_rst_inflight", int'(inflight), 3);
      idle(1'b1);
      chk("rst_inflight", int'(inflight), 0);
      chk("rst_mode", int'(mode), 0);
      idle(1'b0);

      // configuration waits for two outstanding queries to drain
      s2 = seen[2];
      step(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1, 9, 0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1, 9, 0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("drain_cfg_ready", int'(cfg_ready), 0);
      step(1'b0, 1'b1, 1, 9, 0, 1'b0, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1, 9, 0, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("drain_pulses_before", seen[2] - s2, 0);
      step(1'b0, 1'b1, 1, 9, 0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1, 9, 0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(1'b0);
      chk("drain_pulses_after", seen[2] - s2, 1);

      // cfg and query together in idle: cfg wins
      s1 = seen[1];
      s2 = seen[2];
      step(1'b0, 1'b1, 0, 1, 0, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(1'b0);
      chk("prio_cfg_pulses", seen[2] - s2, 1);
      chk("prio_query_pulses", seen[1] - s1, 0);

      for (int i = 0; i < 3000; i++) begin
         int kind;
         kind = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
         step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, kind,
              int'($urandom_range(0, NC - 1)), int'($urandom_range(0, NV - 1)),
              $urandom_range(0, 1) == 1, $urandom_range(0, 7) != 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
      end

      idle(1'b1);
      idle(1'b0);
      idle(1'b0);
      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
